// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code count sequencer.
package gray_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [1:0] MODE_FREE    = 2'b00;
   localparam logic [1:0] MODE_ONESHOT = 2'b01;
   localparam logic [1:0] MODE_STEP    = 2'b10;
   localparam logic [1:0] MODE_FREE_B  = 2'b11;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_count_sequencer_prescaler.sv
// Rate divider: ticks every prescale+1 enabled cycles; a held tick
// stays pending until hold drops.
module tick_prescaler #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             clear,
   input  logic             enable,
   input  logic             hold,
   input  logic [DIV_W-1:0] prescale,
   output logic             tick
);

   logic [DIV_W-1:0] pcnt;
   logic             due;

   assign due  = pcnt >= prescale;
   assign tick = enable && due && !hold;

   always_ff @(posedge clk) begin
      if (clr || clear) begin
         pcnt <= '0;
      end else if (enable) begin
         if (due) begin
            if (!hold) pcnt <= '0;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gray_count_sequencer.sv
// Run/stop/step controller around a binary up-counter, presenting
// each count and its Gray code on a valid/ready output.
module gray_count_sequencer
   import gray_seq_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   input  logic [DIV_W-1:0] prescale,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] bin_q,
   output logic [WIDTH-1:0] gray_q,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   state_t           state;
   state_t           state_n;
   logic [1:0]       mode_l;
   logic [WIDTH-1:0] limit_l;
   logic [WIDTH-1:0] bin_n;
   logic [WIDTH-1:0] gray_n;
   logic             run;
   logic             accept;
   logic             stall;
   logic             step_mode;
   logic             one_shot;
   logic             tick;
   logic             adv;
   logic             hit;

   assign run       = state == RUN;
   assign accept    = start && !stop && !run;
   assign stall     = out_valid && !out_ready;
   assign step_mode = mode_l == MODE_STEP;
   assign one_shot  = mode_l == MODE_ONESHOT;
   assign adv       = run && !stall && (step_mode ? step : tick);
   assign bin_n     = bin_q + 1'b1;
   assign gray_n    = WIDTH'(bin2gray(32'(bin_n)));
   assign hit       = adv && one_shot && (bin_n == limit_l);

   tick_prescaler #(.DIV_W(DIV_W)) u_pre (
      .clk      (clk),
      .clr      (clr),
      .clear    (accept),
      .enable   (run && !step_mode),
      .hold     (stall),
      .prescale (prescale),
      .tick     (tick)
   );

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_n;
   end

   // stop takes priority over a one-shot hit in the same cycle
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = RUN;
         RUN: begin
            if (stop)     state_n = IDLE;
            else if (hit) state_n = DONE;
         end
         DONE:    if (accept) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      busy = state == RUN;
      done = state == DONE;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         bin_q     <= '0;
         gray_q    <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         mode_l    <= MODE_FREE;
         limit_l   <= '0;
      end else begin
         wrap <= 1'b0;
         if (accept) begin
            mode_l  <= mode;
            limit_l <= limit;
            if (state == DONE) begin
               bin_q  <= '0;
               gray_q <= '0;
            end
         end
         if (adv) begin
            bin_q     <= bin_n;
            gray_q    <= gray_n;
            out_valid <= 1'b1;
            wrap      <= &bin_q;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
